// File: rtl/btn_debounce.sv
// Push-button conditioner: polarity fix, synchronizer, counter debouncer and
// press/hold/auto-repeat FSM per button, producing a clean level and one-cycle events.
module btn_debounce #(
  parameter int               N_BTN           = 7,
  parameter logic [N_BTN-1:0] ACTIVE_LOW_MASK = N_BTN'(1),
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter int               HOLD_CYCLES     = 25000000,
  parameter int               REPEAT_CYCLES   = 5000000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_btn_state,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic [N_BTN-1:0] o_hold,
  output logic [N_BTN-1:0] o_repeat
);

  localparam int DC_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HC_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HC_W   = $clog2(HC_MAX + 1);

  localparam logic [DC_W-1:0] DC_LAST   = DC_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [HC_W-1:0] REP_LAST  = HC_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } state_e;

  // Logical level: 1 = pressed for every button after this XOR.
  logic [N_BTN-1:0] btn_l;
  assign btn_l = i_btn ^ ACTIVE_LOW_MASK;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;

    logic [DC_W-1:0]        dc_q, dc_d;
    logic                   level_q, level_d;
    logic                   acc_press, acc_release;

    state_e                 state_q, state_d;
    logic [HC_W-1:0]        hc_q, hc_d;
    logic                   hold_d, rep_d;

    logic                   press_q, release_q, hold_q, repeat_q;

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_l[g]};
      end
    end

    // A mismatch must persist DEBOUNCE_CYCLES consecutive cycles; any return
    // to the accepted level restarts the count.
    always_comb begin
      dc_d        = dc_q;
      level_d     = level_q;
      acc_press   = 1'b0;
      acc_release = 1'b0;
      if (sync_s == level_q) begin
        dc_d = '0;
      end else if (dc_q == DC_LAST) begin
        level_d     = sync_s;
        dc_d        = '0;
        acc_press   = sync_s;
        acc_release = ~sync_s;
      end else begin
        dc_d = dc_q + DC_W'(1);
      end
    end

    // Release takes priority over a hold/repeat landing in the same cycle.
    always_comb begin
      state_d = state_q;
      hc_d    = hc_q;
      hold_d  = 1'b0;
      rep_d   = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (acc_press) begin
            state_d = ST_PRESSED;
            hc_d    = '0;
          end
        end
        ST_PRESSED: begin
          if (acc_release) begin
            state_d = ST_IDLE;
            hc_d    = '0;
          end else if (hc_q == HOLD_LAST) begin
            hold_d  = 1'b1;
            state_d = ST_HELD;
            hc_d    = '0;
          end else begin
            hc_d = hc_q + HC_W'(1);
          end
        end
        ST_HELD: begin
          if (acc_release) begin
            state_d = ST_IDLE;
            hc_d    = '0;
          end else if (REPEAT_CYCLES > 0) begin
            if (hc_q == REP_LAST) begin
              rep_d = 1'b1;
              hc_d  = '0;
            end else begin
              hc_d = hc_q + HC_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          hc_d    = '0;
        end
      endcase
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        dc_q      <= '0;
        level_q   <= 1'b0;
        state_q   <= ST_IDLE;
        hc_q      <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        hold_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        dc_q      <= dc_d;
        level_q   <= level_d;
        state_q   <= state_d;
        hc_q      <= hc_d;
        press_q   <= acc_press;
        release_q <= acc_release;
        hold_q    <= hold_d;
        repeat_q  <= rep_d;
      end
    end

    assign o_btn_state[g] = level_q;
    assign o_press[g]     = press_q;
    assign o_release[g]   = release_q;
    assign o_hold[g]      = hold_q;
    assign o_repeat[g]    = repeat_q;
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: two instances (repeat enabled / disabled)
// share the same stimulus; expected output vectors flow through a scoreboard queue.
module tb_btn_debounce;

  localparam logic [6:0] IDLE_LVL = 7'b0000001;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] btn;

  logic [6:0] a_state, a_press, a_release, a_hold, a_repeat;
  logic [6:0] b_state, b_press, b_release, b_hold, b_repeat;

  int checks = 0;
  int errors = 0;

  logic [34:0] exp_q[$];

  typedef struct {
    logic [6:0] btn;
    logic       rst;
    logic [6:0] st;
    logic [6:0] pr;
    logic [6:0] rl;
    logic [6:0] ho;
    logic [6:0] rp;
  } vec_t;

  vec_t tbl [16];

  // clock / reset
  always #5 clk = ~clk;

  btn_debounce #(
    .N_BTN(7), .ACTIVE_LOW_MASK(7'b0000001), .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_btn(btn),
    .o_btn_state(a_state), .o_press(a_press), .o_release(a_release),
    .o_hold(a_hold), .o_repeat(a_repeat)
  );

  btn_debounce #(
    .N_BTN(7), .ACTIVE_LOW_MASK(7'b0000001), .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(0)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_btn(btn),
    .o_btn_state(b_state), .o_press(b_press), .o_release(b_release),
    .o_hold(b_hold), .o_repeat(b_repeat)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: apply inputs for the next edge and queue what must follow it
  task automatic drive_expect(input logic [6:0] b, input logic r,
                              input logic [6:0] st, input logic [6:0] pr,
                              input logic [6:0] rl, input logic [6:0] ho,
                              input logic [6:0] rp);
    btn = b;
    rst = r;
    exp_q.push_back({st, pr, rl, ho, rp});
  endtask

  // scoreboard: word layout is {state, press, release, hold, repeat}
  task automatic sb_check(input string name, input int e);
    logic [34:0] exp_w;
    logic [34:0] act_a;
    logic [34:0] act_b;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s e=%0d scoreboard empty", name, e);
      return;
    end
    exp_w = exp_q.pop_front();
    act_a = {a_state, a_press, a_release, a_hold, a_repeat};
    act_b = {b_state, b_press, b_release, b_hold, b_repeat};
    checks++;
    if (act_a !== exp_w) begin
      errors++;
      $display("FAIL %s rep3 e=%0d got=%h want=%h", name, e, act_a, exp_w);
    end
    checks++;
    if (act_b !== {exp_w[34:7], 7'b0}) begin
      errors++;
      $display("FAIL %s rep0 e=%0d got=%h want=%h", name, e, act_b, {exp_w[34:7], 7'b0});
    end
  endtask

  task automatic do_reset();
    drive_expect(IDLE_LVL, 1'b1, '0, '0, '0, '0, '0);
    step();
    sb_check("reset_1", 0);
    drive_expect(IDLE_LVL, 1'b1, '0, '0, '0, '0, '0);
    step();
    sb_check("reset_2", 1);
    drive_expect(IDLE_LVL, 1'b0, '0, '0, '0, '0, '0);
    step();
    sb_check("post_reset", 2);
  endtask

  task automatic run_table(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      drive_expect(tbl[i].btn, tbl[i].rst, tbl[i].st, tbl[i].pr,
                   tbl[i].rl, tbl[i].ho, tbl[i].rp);
      step();
      sb_check(name, i);
    end
  endtask

  // Press `mask` at e=0, release at rel_at, optional 1-cycle reset at rst_at.
  // Press lands 5 edges after first sample (6 after a reset), hold 10 later,
  // repeats every 3 after that; release lands 5 edges after its first sample.
  task automatic run_hold(input string name, input logic [6:0] mask,
                          input int rel_at, input int rst_at, input int n);
    for (int e = 0; e < n; e++) begin
      int p;
      int r;
      logic [6:0] st, pr, rl, ho, rp;
      p  = (rst_at >= 0 && e > rst_at) ? rst_at + 6 : 5;
      r  = rel_at + 5;
      st = '0; pr = '0; rl = '0; ho = '0; rp = '0;
      if (e != rst_at) begin
        if (e >= p && e < r) st = mask;
        if (e == p) pr = mask;
        if (e == r && r > p) rl = mask;
        if (e == p + 10 && e < r) ho = mask;
        if (e > p + 10 && e < r && ((e - p - 10) % 3) == 0) rp = mask;
      end
      drive_expect(IDLE_LVL ^ ((e < rel_at) ? mask : 7'b0), (e == rst_at),
                   st, pr, rl, ho, rp);
      step();
      sb_check(name, e);
    end
  endtask

  initial begin
    btn = IDLE_LVL;
    rst = 1'b1;

    // clean press on button 3, held 40 cycles; release coincides with a repeat slot
    do_reset();
    run_hold("t1_press_hold", 7'h08, 40, -1, 50);

    // bounce on button 2: 1,0,1,0 then steady 1
    do_reset();
    for (int i = 0; i < 15; i++) begin
      tbl[i] = '{btn: IDLE_LVL | 7'h04, rst: 1'b0, st: (i >= 9) ? 7'h04 : 7'h00,
                 pr: 7'h00, rl: 7'h00, ho: 7'h00, rp: 7'h00};
    end
    tbl[1].btn = IDLE_LVL;
    tbl[3].btn = IDLE_LVL;
    tbl[9].pr  = 7'h04;
    run_table("t2_bounce", 15);

    // active-low button 0: pressed for 8 samples then released
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tbl[i] = '{btn: (i < 8) ? 7'h00 : IDLE_LVL, rst: 1'b0,
                 st: (i >= 5 && i < 13) ? 7'h01 : 7'h00,
                 pr: 7'h00, rl: 7'h00, ho: 7'h00, rp: 7'h00};
    end
    tbl[5].pr  = 7'h01;
    tbl[13].rl = 7'h01;
    run_table("t3_active_low", 16);
    run_hold("t3_active_low_hold", 7'h01, 20, -1, 30);

    // release accepted exactly when hold would fire, then a fresh press
    do_reset();
    run_hold("t4_rel_at_hold", 7'h02, 10, -1, 20);
    run_hold("t4_repress", 7'h02, 30, -1, 40);

    // reset while HELD with the button still down
    do_reset();
    run_hold("t5_mid_reset", 7'h02, 42, 20, 42);

    // three buttons pressed together
    do_reset();
    run_hold("t6_multi", 7'h70, 40, -1, 50);

    do_reset();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got=%0d want=0 leftover entries", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
